// File: rtl/param_serial_sub.sv
// Bit-serial subtractor: A - B one bit per clock, LSB first.
// Result is {borrow_out, diff} with a signed-overflow flag.
module param_serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic [WIDTH-1:0] sd_nx;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic             borrow_nx;
   logic             d;
   logic             a_msb;
   logic             b_msb;

   always_comb begin
      d         = sa[0] ^ sb[0] ^ borrow;
      borrow_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
      // diff bits enter at the top so the LSB ends at bit 0
      sd_nx            = sd >> 1;
      sd_nx[WIDTH-1]   = d;
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sd     <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               sd     <= sd_nx;
               borrow <= borrow_nx;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= DONE;
                  result <= {borrow_nx, sd_nx};
                  ovf    <= (a_msb ^ b_msb)
                          & (a_msb ^ sd_nx[WIDTH-1]);
               end
            end
            default: begin
               if (start) begin
                  sa     <= A;
                  sb     <= B;
                  sd     <= '0;
                  cnt    <= '0;
                  borrow <= 1'b0;
                  a_msb  <= A[WIDTH-1];
                  b_msb  <= B[WIDTH-1];
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_serial_sub.sv
// Bench for param_serial_sub: WIDTH 4, 1 and 16 instances
// sharing clock, reset and start.
module tb_param_serial_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic [3:0]  a4, b4;
   logic [0:0]  a1, b1;
   logic [15:0] a16, b16;
   logic        busy4, done4, ovf4;
   logic        busy1, done1, ovf1;
   logic        busy16, done16, ovf16;
   logic [4:0]  result4;
   logic [1:0]  result1;
   logic [16:0] result16;

   param_serial_sub #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .A(a4), .B(b4), .busy(busy4), .done(done4),
      .result(result4), .ovf(ovf4)
   );
   param_serial_sub #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .A(a1), .B(b1), .busy(busy1), .done(done1),
      .result(result1), .ovf(ovf1)
   );
   param_serial_sub #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .A(a16), .B(b16), .busy(busy16), .done(done16),
      .result(result16), .ovf(ovf16)
   );

   int applied = 0;
   int miscomp = 0;

   longint r[3], o[3], c[3];
   longint hold4, busyc4;
   longint prev4;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] r;
      logic       o;
   } vec_t;
   vec_t tbl[6];

   task automatic check(string nm, longint act, longint exp);
      applied++;
      if (act !== exp) begin
         miscomp++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic of A - B at width w
   function automatic void model(int w, longint a, longint b,
                                 output longint res,
                                 output longint ov);
      longint m, h, sa, sb, sd;
      m   = longint'(1) << w;
      h   = m >> 1;
      sa  = (a >= h) ? a - m : a;
      sb  = (b >= h) ? b - m : b;
      sd  = sa - sb;
      res = ((a < b) ? m : 0) + ((a - b + m) % m);
      ov  = (sd >= h || sd < -h) ? 1 : 0;
   endfunction

   task automatic op(longint x4, longint y4, longint x1,
                     longint y1, longint x16, longint y16);
      @(negedge clk);
      a4 = x4[3:0]; b4 = y4[3:0];
      a1 = x1[0:0]; b1 = y1[0:0];
      a16 = x16[15:0]; b16 = y16[15:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      for (int k = 0; k < 3; k++) c[k] = -1;
      busyc4 = 0;
      hold4 = result4;
      for (int n = 0; n < 20; n++) begin
         if (busy4) busyc4++;
         if (done4 && c[0] < 0) begin
            c[0] = n; r[0] = result4; o[0] = ovf4;
         end
         if (done1 && c[1] < 0) begin
            c[1] = n; r[1] = result1; o[1] = ovf1;
         end
         if (done16 && c[2] < 0) begin
            c[2] = n; r[2] = result16; o[2] = ovf16;
         end
         if (n < 19) @(negedge clk);
      end
   endtask

   task automatic run_check(longint x4, longint y4,
                            longint er, longint eo,
                            longint x1, longint y1,
                            longint x16, longint y16);
      longint mr, mo;
      op(x4, y4, x1, y1, x16, y16);
      check("w4_hold", hold4, prev4);
      check("w4_lat", c[0], 4);
      check("w4_busy", busyc4, 4);
      check("w4_res", r[0], er);
      check("w4_ovf", o[0], eo);
      prev4 = er;
      model(1, x1, y1, mr, mo);
      check("w1_lat", c[1], 1);
      check("w1_res", r[1], mr);
      check("w1_ovf", o[1], mo);
      model(16, x16, y16, mr, mo);
      check("w16_lat", c[2], 16);
      check("w16_res", r[2], mr);
      check("w16_ovf", o[2], mo);
   endtask

   initial begin
      longint er, eo, x, y, x16, y16;
      int nd;
      longint dt[2], dr[2];
      int seen;

      tbl[0] = '{4'd9, 4'd3, 5'b0_0110, 1'b1};
      tbl[1] = '{4'd3, 4'd9, 5'b1_1010, 1'b1};
      tbl[2] = '{4'd0, 4'd1, 5'b1_1111, 1'b0};
      tbl[3] = '{4'd0, 4'd0, 5'b0_0000, 1'b0};
      tbl[4] = '{4'h8, 4'h1, 5'b0_0111, 1'b1};
      tbl[5] = '{4'h7, 4'hF, 5'b1_1000, 1'b1};

      rst_n = 1'b0; start = 1'b0;
      a4 = '0; b4 = '0; a1 = '0; b1 = '0;
      a16 = '0; b16 = '0;
      prev4 = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_res", result4, 0);
      check("rst_ovf", ovf4, 0);

      foreach (tbl[i]) begin
         x16 = (i == 1) ? 0 : (i == 2) ? 16'h8000
             : longint'($urandom_range(0, 65535));
         y16 = (i == 1) ? 16'hFFFF : (i == 2) ? 1
             : longint'($urandom_range(0, 65535));
         run_check(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].o,
                   (i == 0) ? 0 : i % 2, (i == 0) ? 1 : i / 2 % 2,
                   x16, y16);
      end

      for (int i = 0; i < 40; i++) begin
         x = longint'($urandom_range(0, 15));
         y = longint'($urandom_range(0, 15));
         model(4, x, y, er, eo);
         run_check(x, y, er, eo,
                   longint'($urandom_range(0, 1)),
                   longint'($urandom_range(0, 1)),
                   longint'($urandom_range(0, 65535)),
                   longint'($urandom_range(0, 65535)));
      end

      // start held high: mid-run start ignored, DONE accepts
      @(negedge clk);
      a4 = 4'd5; b4 = 4'd2; start = 1'b1;
      @(negedge clk);
      a4 = 4'd2; b4 = 4'd5;
      check("b2b_busy", busy4, 1);
      nd = 0; dt[0] = -1; dt[1] = -1; dr[0] = -1; dr[1] = -1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (done4) begin
            if (nd < 2) begin
               dt[nd] = n; dr[nd] = result4;
            end
            nd++;
         end
         if (n == 5) start = 1'b0;
      end
      check("b2b_count", nd, 2);
      check("b2b_first_t", dt[0], 4);
      check("b2b_res0", dr[0], 5'b0_0011);
      check("b2b_res1", dr[1], 5'b1_1101);
      check("b2b_gap", dt[1] - dt[0], 5);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      a4 = 4'd15; b4 = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy4, 0);
      check("arst_done", done4, 0);
      check("arst_res", result4, 0);
      check("arst_ovf", ovf4, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done4) seen++;
      end
      check("arst_nodone", seen, 0);
      prev4 = 0;
      run_check(9, 3, 5'b0_0110, 1, 0, 1, 16'h1234, 16'h4321);

      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscomp);
      $finish;
   end

endmodule
